// File: rtl/if_pc_stage_if.sv
// -----------------------------------------------------------------------------
// if_pc_stage_if
// Bundle of the redirect/control inputs and the PC-side outputs of the
// instruction-fetch PC stage.
//   slave  : the PC stage itself (consumes redirects, drives PC outputs)
//   master : the surrounding pipeline (hazard unit, ID, EX, interrupt source)
// Signals:
//   iPC_write       hazard-unit write enable, 0 = stall PC
//   iBranch_taken   EX-stage branch resolved taken
//   iBranch_target  EX-stage branch target
//   iJump           ID-stage j/jal
//   iJump_index     ID-stage instr[25:0]
//   iJr             ID-stage jr/jalr
//   iJr_target      forwarded register value for jr/jalr
//   iException      ID-stage illegal-op exception
//   iIRQ            external interrupt request (level or pulse)
//   oPC             current PC / instruction-memory address
//   oPC_plus_4      PC+4 with the kernel bit preserved, to IF/ID
//   oIFID_flush     squash the instruction currently in IF
//   oIRQ_taken      one-cycle pulse when an interrupt redirect commits
//   oEPC            return address captured on interrupt
// -----------------------------------------------------------------------------
interface if_pc_stage_if;
    logic        iPC_write;
    logic        iBranch_taken;
    logic [31:0] iBranch_target;
    logic        iJump;
    logic [25:0] iJump_index;
    logic        iJr;
    logic [31:0] iJr_target;
    logic        iException;
    logic        iIRQ;
    logic [31:0] oPC;
    logic [31:0] oPC_plus_4;
    logic        oIFID_flush;
    logic        oIRQ_taken;
    logic [31:0] oEPC;

    modport slave (
        input  iPC_write, iBranch_taken, iBranch_target, iJump, iJump_index,
               iJr, iJr_target, iException, iIRQ,
        output oPC, oPC_plus_4, oIFID_flush, oIRQ_taken, oEPC
    );

    modport master (
        output iPC_write, iBranch_taken, iBranch_target, iJump, iJump_index,
               iJr, iJr_target, iException, iIRQ,
        input  oPC, oPC_plus_4, oIFID_flush, oIRQ_taken, oEPC
    );
endinterface

// File: rtl/if_pc_stage.sv
// -----------------------------------------------------------------------------
// if_pc_stage
// Instruction-fetch PC stage sitting directly in front of the IF/ID register.
// Owns the program counter and picks the next PC from: exception vector,
// EX-stage branch, ID-stage jr, ID-stage jump, interrupt vector, sequential
// PC+4, or hold. Latches pending interrupts, captures the EPC and requests an
// IF/ID flush whenever it redirects.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high reset
//   bus    if_pc_stage_if.slave (redirect inputs, PC/EPC/flush outputs)
// -----------------------------------------------------------------------------
module if_pc_stage #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0008
) (
    input  logic          clk,
    input  logic          reset,
    if_pc_stage_if.slave  bus
);

    logic [31:0] pc_q,          pc_d;
    logic        irq_pending_q, irq_pending_d;
    logic [31:0] epc_q,         epc_d;
    logic        irq_taken_q,   irq_taken_d;

    logic [31:0] pc_plus_4_s;
    logic        flush_s;

    // Sequential increment that never touches the kernel bit: the low 31 bits
    // wrap on their own and bit 31 is copied through unchanged.
    always_comb begin
        pc_plus_4_s = {pc_q[31], pc_q[30:0] + 31'd4};
    end

    // Next-PC selection, interrupt bookkeeping and flush request.
    always_comb begin
        pc_d          = pc_q;
        irq_pending_d = irq_pending_q | bus.iIRQ;
        epc_d         = epc_q;
        irq_taken_d   = 1'b0;
        flush_s       = 1'b0;

        // Exception and branch come from older instructions than the one
        // being stalled, so they redirect even when iPC_write is low.
        if (bus.iException) begin
            pc_d    = EXC_VECTOR;
            flush_s = 1'b1;
        end else if (bus.iBranch_taken) begin
            pc_d    = bus.iBranch_target;
            flush_s = 1'b1;
        end else if (bus.iPC_write) begin
            if (bus.iJr) begin
                // Target may have bit 31 clear: this is the return to user mode.
                pc_d    = bus.iJr_target;
                flush_s = 1'b1;
            end else if (bus.iJump) begin
                pc_d    = {pc_plus_4_s[31:28], bus.iJump_index, 2'b00};
                flush_s = 1'b1;
            end else if (irq_pending_q && !pc_q[31]) begin
                // Interrupts are only accepted from user mode. Taking one
                // clears the pending flag even if iIRQ is still asserted.
                pc_d          = IRQ_VECTOR;
                epc_d         = pc_q;
                irq_taken_d   = 1'b1;
                irq_pending_d = 1'b0;
                flush_s       = 1'b1;
            end else begin
                pc_d = pc_plus_4_s;
            end
        end else begin
            pc_d = pc_q;
        end
    end

    // State registers; reset also discards whatever redirect was presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            irq_pending_q <= 1'b0;
            epc_q         <= 32'h0000_0000;
            irq_taken_q   <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            irq_pending_q <= irq_pending_d;
            epc_q         <= epc_d;
            irq_taken_q   <= irq_taken_d;
        end
    end

    assign bus.oPC         = pc_q;
    assign bus.oPC_plus_4  = pc_plus_4_s;
    assign bus.oIFID_flush = flush_s;
    assign bus.oIRQ_taken  = irq_taken_q;
    assign bus.oEPC        = epc_q;

endmodule

// File: tb/tb_if_pc_stage.sv
// -----------------------------------------------------------------------------
// tb_if_pc_stage
// Self-checking bench for if_pc_stage: directed scenarios with literal
// expectations, then randomized redirects, all checked every cycle against a
// behavioural model of the fetch PC.
// -----------------------------------------------------------------------------
module tb_if_pc_stage;

    localparam logic [31:0] RESET_PC   = 32'h8000_0000;
    localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    if_pc_stage_if bus ();

    if_pc_stage #(
        .RESET_PC   (RESET_PC),
        .IRQ_VECTOR (IRQ_VECTOR),
        .EXC_VECTOR (EXC_VECTOR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_epc;
    logic        m_taken;

    function automatic logic [31:0] plus4(input logic [31:0] pc);
        return (pc & 32'h8000_0000) | ((pc + 32'd4) & 32'h7FFF_FFFF);
    endfunction

    // Which rule (1..7) the current inputs and model state select.
    function automatic int rule_now();
        if (bus.iException)                   return 1;
        if (bus.iBranch_taken)                return 2;
        if (!bus.iPC_write)                   return 7;
        if (bus.iJr)                          return 3;
        if (bus.iJump)                        return 4;
        if (m_pend && (m_pc < 32'h8000_0000)) return 5;
        return 6;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc    <= RESET_PC;
            m_pend  <= 1'b0;
            m_epc   <= 32'd0;
            m_taken <= 1'b0;
        end else begin
            int r;
            r = rule_now();
            case (r)
                1:       m_pc <= EXC_VECTOR;
                2:       m_pc <= bus.iBranch_target;
                3:       m_pc <= bus.iJr_target;
                4:       m_pc <= (plus4(m_pc) & 32'hF000_0000) | {4'd0, bus.iJump_index, 2'b00};
                5:       m_pc <= IRQ_VECTOR;
                6:       m_pc <= plus4(m_pc);
                default: m_pc <= m_pc;
            endcase
            m_taken <= (r == 5);
            m_pend  <= (r == 5) ? 1'b0 : (m_pend | bus.iIRQ);
            if (r == 5) m_epc <= m_pc;
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        chk("pc",        bus.oPC,        m_pc);
        chk("pc_plus_4", bus.oPC_plus_4, plus4(m_pc));
        chk("epc",       bus.oEPC,       m_epc);
        chk("irq_taken", {31'd0, bus.oIRQ_taken},  {31'd0, m_taken});
        chk("flush",     {31'd0, bus.oIFID_flush}, {31'd0, (rule_now() <= 5)});
    end

    // ---------------- stimulus helpers ----------------
    task automatic setin(input logic pw, input logic br, input logic [31:0] bt,
                         input logic j, input logic [25:0] ji,
                         input logic jr, input logic [31:0] jt,
                         input logic exc, input logic irq);
        bus.iPC_write      = pw;
        bus.iBranch_taken  = br;
        bus.iBranch_target = bt;
        bus.iJump          = j;
        bus.iJump_index    = ji;
        bus.iJr            = jr;
        bus.iJr_target     = jt;
        bus.iException     = exc;
        bus.iIRQ           = irq;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic seq();
        setin(1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic do_jr(input logic [31:0] t, input logic irq);
        setin(1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b1, t, 1'b0, irq);
        tick();
    endtask

    initial begin
        setin(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        #11;
        chk("reset_pc", bus.oPC, 32'h8000_0000);
        reset = 1'b0;
        #1;

        // Reach a user-mode PC and free-run.
        do_jr(32'h0040_0000, 1'b0);
        chk("jr_pc", bus.oPC, 32'h0040_0000);
        seq();
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk("seq_flush", {31'd0, bus.oIFID_flush}, 32'd0);
            tick();
            chk("seq_pc", bus.oPC, 32'h0040_0000 + 32'd4 * i);
        end
        tick();
        chk("seq_pc4", bus.oPC, 32'h0040_0010);

        // Stall, then branch overriding the stall.
        setin(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        chk("stall_pc", bus.oPC, 32'h0040_0010);
        setin(1'b0, 1'b0, 32'd0, 1'b1, 26'h0100040, 1'b1, 32'h0040_0400, 1'b0, 1'b0);
        tick();
        chk("stall_jump_hold", bus.oPC, 32'h0040_0010);
        setin(1'b0, 1'b1, 32'h0040_0100, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        #1;
        chk("branch_flush", {31'd0, bus.oIFID_flush}, 32'd1);
        tick();
        chk("branch_pc", bus.oPC, 32'h0040_0100);

        // Branch beats a simultaneous jump; then a plain jump.
        do_jr(32'h0040_0020, 1'b0);
        setin(1'b1, 1'b1, 32'h0040_0200, 1'b1, 26'h0100040, 1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        chk("branch_wins", bus.oPC, 32'h0040_0200);
        setin(1'b1, 1'b0, 32'd0, 1'b1, 26'h0100040, 1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        chk("jump_pc", bus.oPC, 32'h0040_0100);

        // Interrupt arrives in kernel mode: deferred until jr to user.
        do_jr(32'h8000_0040, 1'b0);
        setin(1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        tick();
        chk("kirq_pc", bus.oPC, 32'h8000_0044);
        seq();
        tick();
        chk("kirq_pc2", bus.oPC, 32'h8000_0048);
        chk("kirq_taken", {31'd0, bus.oIRQ_taken}, 32'd0);
        do_jr(32'h0040_0050, 1'b0);
        chk("user_pc", bus.oPC, 32'h0040_0050);
        seq();
        #1;
        chk("irq_flush", {31'd0, bus.oIFID_flush}, 32'd1);
        tick();
        chk("irq_pc", bus.oPC, 32'h8000_0004);
        chk("irq_epc", bus.oEPC, 32'h0040_0050);
        chk("irq_taken", {31'd0, bus.oIRQ_taken}, 32'd1);
        tick();
        chk("irq_taken_pulse", {31'd0, bus.oIRQ_taken}, 32'd0);
        chk("irq_after_pc", bus.oPC, 32'h8000_0008);

        // Exception beats a pending interrupt; interrupt stays pending.
        do_jr(32'h0040_0060, 1'b1);
        setin(1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b1, 1'b0);
        #1;
        chk("exc_flush", {31'd0, bus.oIFID_flush}, 32'd1);
        tick();
        chk("exc_pc", bus.oPC, 32'h8000_0008);
        chk("exc_taken", {31'd0, bus.oIRQ_taken}, 32'd0);
        seq();
        tick();
        chk("exc_kpc", bus.oPC, 32'h8000_000C);
        do_jr(32'h0040_0070, 1'b0);
        seq();
        tick();
        chk("late_irq_pc", bus.oPC, 32'h8000_0004);
        chk("late_irq_epc", bus.oEPC, 32'h0040_0070);

        // Increment wrap with the kernel bit preserved.
        do_jr(32'hFFFF_FFFC, 1'b0);
        chk("wrap_k_plus4", bus.oPC_plus_4, 32'h8000_0000);
        seq();
        tick();
        chk("wrap_k_pc", bus.oPC, 32'h8000_0000);
        do_jr(32'h7FFF_FFFC, 1'b0);
        chk("wrap_u_plus4", bus.oPC_plus_4, 32'h0000_0000);

        // Asynchronous reset mid-cycle with a redirect on the inputs.
        setin(1'b1, 1'b1, 32'h0040_0300, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_pc",    bus.oPC,        32'h8000_0000);
        chk("rst_plus4", bus.oPC_plus_4, 32'h8000_0004);
        chk("rst_epc",   bus.oEPC,       32'h0000_0000);
        chk("rst_taken", {31'd0, bus.oIRQ_taken}, 32'd0);
        tick();
        reset = 1'b0;
        chk("rst_discard", bus.oPC, 32'h8000_0000);

        // Randomized phase, checked by the model every cycle.
        for (int n = 0; n < 2000; n++) begin
            setin(($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 9) == 0),
                  {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 29'($urandom), 2'b00},
                  ($urandom_range(0, 9) == 0),
                  26'($urandom),
                  ($urandom_range(0, 11) == 0),
                  {($urandom_range(0, 2) == 0), 29'($urandom), 2'b00},
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 9) == 0));
            tick();
        end

        setin(1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_pc_stage.md
Name: if_pc_stage

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the program counter and selects the next PC from these sources: sequential, branch (resolved in EX), jump/jr (resolved in ID), interrupt vector and exception vector. It drives the instruction-memory address and the PC+4 value that enters IF/ID. It also latches pending interrupts, captures the EPC, and requests an IF/ID flush on every redirect.

Parameters:
RESET_PC, 32'h80000000, PC value loaded on reset (kernel space).
IRQ_VECTOR, 32'h80000004, interrupt handler address.
EXC_VECTOR, 32'h80000008, exception handler address.

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
iPC_write  input  1  hazard-unit write enable; 0 = stall PC
iBranch_taken  input  1  EX-stage branch resolved taken
iBranch_target  input  32  EX-stage branch target
iJump  input  1  ID-stage j/jal
iJump_index  input  26  ID-stage instr[25:0]
iJr  input  1  ID-stage jr/jalr
iJr_target  input  32  forwarded register value
iException  input  1  ID-stage illegal-op exception
iIRQ  input  1  external interrupt request, level or pulse
oPC  output  32  current PC / instruction-memory address
oPC_plus_4  output  32  PC+4 with kernel bit preserved, to IF/ID
oIFID_flush  output  1  squash the instruction in IF (combinational)
oIRQ_taken  output  1  one-cycle pulse when the interrupt redirect is committed
oEPC  output  32  return address captured on interrupt

Behaviour:
- Reset (async, highest priority): PC=RESET_PC, irq_pending=0, oEPC=0, oIRQ_taken=0. Reset asserted mid-stream discards any pending redirect.
- oPC_plus_4 = {PC[31], PC[30:0]+31'd4}, combinational. Bit 31 is never carried into or cleared by the increment; PC[30:0]=7FFFFFFC wraps to 0 with bit 31 unchanged.
- Kernel mode is PC[31]==1.
- irq_pending: set on any clk edge with iIRQ=1. Cleared on the edge where the interrupt is taken; if iIRQ is still high on that edge, clear wins.
- Next-PC priority, evaluated each edge:
  1. iException -> EXC_VECTOR.
  2. iBranch_taken -> iBranch_target.
  3. iJr and iPC_write -> iJr_target (may clear bit 31, i.e. return to user mode).
  4. iJump and iPC_write -> {oPC_plus_4[31:28], iJump_index, 2'b00}.
  5. irq_pending and PC[31]==0 and iPC_write -> IRQ_VECTOR; oEPC<=PC; oIRQ_taken=1 for that one cycle.
  6. iPC_write -> oPC_plus_4.
  7. else hold PC.
- Exception and branch override a stall (iPC_write=0), because the redirecting instruction is older than the stalled one. Jump, jr and interrupt wait while stalled.
- Interrupts are never taken in kernel mode; they stay pending until PC[31] becomes 0.
- oIFID_flush=1 in any cycle where rule 1–5 fires; otherwise 0.
- Latency: a redirect takes effect on oPC one cycle after it is presented. No bubble beyond the flushed slot.
- Simultaneous events: the lower-numbered rule wins and the others are dropped. A losing irq_pending is not cleared.

Test Plan:
- Reset pulse mid-run -> oPC=80000000, oPC_plus_4=80000004, oEPC=0, oIRQ_taken=0, all immediately (asynchronous).
- 3 free-running cycles from PC=00400000 -> oPC 00400004, 00400008, 0040000C; oIFID_flush=0 throughout.
- iPC_write=0 for 2 cycles at PC=00400010 -> PC holds; same cycle iBranch_taken=1, target=00400100 -> next oPC=00400100, oIFID_flush=1.
- iJump=1, iJump_index=0x0100040, PC=00400020, together with iBranch_taken=1, target=00400200 -> branch wins, next oPC=00400200.
- iIRQ pulse while PC=80000040 -> no redirect. Later jr to 00400050 -> IRQ taken next cycle: oEPC=00400050, oPC=80000004, oIRQ_taken=1 for exactly 1 cycle, pending cleared.
- iException=1 with iIRQ pending and PC=00400060 -> oPC=80000008, interrupt stays pending (oIRQ_taken=0).
